// File: rtl/pic_control_unit.sv
// Interrupt-controller control core: ICW/OCW decode, IMR/ISR, rotating priority,
// two-pulse INTA sequencing with vector generation, AEOI and poll mode.
module pic_control_unit #(
  parameter int NUM_IRQ = 8,
  parameter int LVL_W   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic               wr_a0,
  input  logic [7:0]         wr_data,
  input  logic               rd_en,
  input  logic               rd_a0,
  output logic [7:0]         rd_data,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic               inta,
  output logic               int_out,
  output logic [7:0]         vector_out,
  output logic               vector_valid,
  output logic [NUM_IRQ-1:0] clear_req,
  output logic [NUM_IRQ-1:0] isr,
  output logic [NUM_IRQ-1:0] imr
);

  typedef enum logic [2:0] {
    UNINIT, W_ICW2, W_ICW3, W_ICW4, READY
  } init_t;

  typedef enum logic {A_IDLE, A_WAIT2} ack_t;

  typedef struct packed {
    logic             found;
    logic [LVL_W-1:0] lvl;
    logic [LVL_W-1:0] rank;
  } prio_t;

  localparam logic [LVL_W-1:0] LAST = LVL_W'(NUM_IRQ - 1);

  init_t init_q, init_n;
  ack_t  ack_q, ack_n;

  logic             sngl_q, sngl_n;
  logic             ic4_q, ic4_n;
  logic [4:0]       base_q, base_n;
  logic [7:0]       icw3_q, icw3_n;
  logic             aeoi_q, aeoi_n;
  logic             rot_q, rot_n;
  logic             rsel_q, rsel_n;
  logic             poll_q, poll_n;
  logic             spur_q, spur_n;
  logic [LVL_W-1:0] lp_q, lp_n;
  logic [LVL_W-1:0] lvl_q, lvl_n;

  logic [NUM_IRQ-1:0] isr_n, imr_n, clr_n;
  logic [7:0]         rd_n, vec_n;
  logic               vv_n, int_n;

  prio_t cand, isr_top;
  logic  icw1;
  logic  l_ok;

  // Index i=1 is the top level; scanning downward lets it win last.
  function automatic prio_t resolve(
    input logic [NUM_IRQ-1:0] v,
    input logic [LVL_W-1:0]   lp
  );
    prio_t r;
    int    idx;
    r = '0;
    for (int i = NUM_IRQ; i >= 1; i--) begin
      idx = int'(lp) + i;
      if (idx >= NUM_IRQ) idx = idx - NUM_IRQ;
      if (v[LVL_W'(idx)]) begin
        r.found = 1'b1;
        r.lvl   = LVL_W'(idx);
        r.rank  = LVL_W'(i - 1);
      end
    end
    return r;
  endfunction

  always_comb begin
    cand    = resolve(irq_req & ~imr, lp_q);
    isr_top = resolve(isr, lp_q);
    icw1    = wr_en && !wr_a0 && wr_data[4];
    l_ok    = int'(wr_data[2:0]) < NUM_IRQ;

    init_n = init_q;
    ack_n  = ack_q;
    sngl_n = sngl_q;
    ic4_n  = ic4_q;
    base_n = base_q;
    icw3_n = icw3_q;
    aeoi_n = aeoi_q;
    rot_n  = rot_q;
    rsel_n = rsel_q;
    poll_n = poll_q;
    spur_n = spur_q;
    lp_n   = lp_q;
    lvl_n  = lvl_q;
    isr_n  = isr;
    imr_n  = imr;
    clr_n  = '0;
    rd_n   = rd_data;
    vec_n  = vector_out;
    vv_n   = 1'b0;

    if (inta && init_q == READY) begin
      if (ack_q == A_IDLE) begin
        ack_n = A_WAIT2;
        if (cand.found) begin
          lvl_n            = cand.lvl;
          spur_n           = 1'b0;
          isr_n[cand.lvl]  = 1'b1;
          clr_n[cand.lvl]  = 1'b1;
        end else begin
          lvl_n  = LAST;
          spur_n = 1'b1;
        end
      end else begin
        ack_n = A_IDLE;
        vec_n = {base_q, 3'b000} | 8'(lvl_q);
        vv_n  = 1'b1;
        if (aeoi_q && !spur_q) begin
          isr_n[lvl_q] = 1'b0;
          if (rot_q) lp_n = lvl_q;
        end
      end
    end

    if (rd_en) begin
      if (rd_a0) begin
        rd_n = 8'(imr);
      end else if (poll_q) begin
        rd_n   = {cand.found, 4'b0000, 3'(cand.lvl)};
        poll_n = 1'b0;
        if (cand.found) begin
          isr_n[cand.lvl] = 1'b1;
          clr_n[cand.lvl] = 1'b1;
        end
      end else begin
        rd_n = rsel_q ? 8'(isr) : 8'(irq_req);
      end
    end

    // ICW1 restarts init and overrides any acknowledge activity this cycle.
    if (icw1) begin
      init_n = W_ICW2;
      sngl_n = wr_data[1];
      ic4_n  = wr_data[0];
      imr_n  = '1;
      isr_n  = '0;
      lp_n   = LAST;
      aeoi_n = 1'b0;
      rot_n  = 1'b0;
      rsel_n = 1'b0;
      poll_n = 1'b0;
      ack_n  = A_IDLE;
      clr_n  = '0;
      vv_n   = 1'b0;
    end else if (wr_en) begin
      unique case (init_q)
        W_ICW2: if (wr_a0) begin
          base_n = wr_data[7:3];
          init_n = !sngl_q ? W_ICW3 : (ic4_q ? W_ICW4 : READY);
        end
        W_ICW3: if (wr_a0) begin
          icw3_n = wr_data;
          init_n = ic4_q ? W_ICW4 : READY;
        end
        W_ICW4: if (wr_a0) begin
          aeoi_n = wr_data[1];
          init_n = READY;
        end
        READY: begin
          if (wr_a0) begin
            imr_n = wr_data[NUM_IRQ-1:0];
          end else if (wr_data[4:3] == 2'b00) begin
            unique case (wr_data[7:5])
              3'b001: if (isr_top.found) isr_n[isr_top.lvl] = 1'b0;
              3'b101: if (isr_top.found) begin
                isr_n[isr_top.lvl] = 1'b0;
                lp_n               = isr_top.lvl;
              end
              3'b011: if (l_ok) isr_n[LVL_W'(wr_data[2:0])] = 1'b0;
              3'b111: if (l_ok) begin
                isr_n[LVL_W'(wr_data[2:0])] = 1'b0;
                lp_n                        = LVL_W'(wr_data[2:0]);
              end
              3'b110: if (l_ok) lp_n = LVL_W'(wr_data[2:0]);
              3'b100: rot_n = 1'b1;
              3'b000: rot_n = 1'b0;
              default: ;
            endcase
          end else if (wr_data[4:3] == 2'b01) begin
            if (wr_data[1]) rsel_n = wr_data[0];
            if (wr_data[2]) poll_n = 1'b1;
          end
        end
        default: ;
      endcase
    end

    int_n = (init_n == READY) && (ack_n == A_IDLE) && cand.found &&
            (!isr_top.found || cand.rank < isr_top.rank);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      init_q       <= UNINIT;
      ack_q        <= A_IDLE;
      sngl_q       <= 1'b0;
      ic4_q        <= 1'b0;
      base_q       <= '0;
      icw3_q       <= '0;
      aeoi_q       <= 1'b0;
      rot_q        <= 1'b0;
      rsel_q       <= 1'b0;
      poll_q       <= 1'b0;
      spur_q       <= 1'b0;
      lp_q         <= LAST;
      lvl_q        <= '0;
      isr          <= '0;
      imr          <= '1;
      clear_req    <= '0;
      rd_data      <= '0;
      vector_out   <= '0;
      vector_valid <= 1'b0;
      int_out      <= 1'b0;
    end else begin
      init_q       <= init_n;
      ack_q        <= ack_n;
      sngl_q       <= sngl_n;
      ic4_q        <= ic4_n;
      base_q       <= base_n;
      icw3_q       <= icw3_n;
      aeoi_q       <= aeoi_n;
      rot_q        <= rot_n;
      rsel_q       <= rsel_n;
      poll_q       <= poll_n;
      spur_q       <= spur_n;
      lp_q         <= lp_n;
      lvl_q        <= lvl_n;
      isr          <= isr_n;
      imr          <= imr_n;
      clear_req    <= clr_n;
      rd_data      <= rd_n;
      vector_out   <= vec_n;
      vector_valid <= vv_n;
      int_out      <= int_n;
    end
  end

endmodule

// File: tb/tb_pic_control_unit.sv
// Directed bench for pic_control_unit: init, nesting, EOI, AEOI rotate,
// set-priority, spurious ack, poll, reads and ICW1 abort.
module tb_pic_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en, wr_a0, rd_en, rd_a0, inta;
  logic [7:0] wr_data, rd_data, irq_req;
  logic       int_out, vector_valid;
  logic [7:0] vector_out, clear_req, isr, imr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pic_control_unit #(.NUM_IRQ(8), .LVL_W(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_a0        (wr_a0),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_a0        (rd_a0),
    .rd_data      (rd_data),
    .irq_req      (irq_req),
    .inta         (inta),
    .int_out      (int_out),
    .vector_out   (vector_out),
    .vector_valid (vector_valid),
    .clear_req    (clear_req),
    .isr          (isr),
    .imr          (imr)
  );

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic a0, input logic [7:0] d);
    wr_en = 1'b1; wr_a0 = a0; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic a0);
    rd_en = 1'b1; rd_a0 = a0;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic ack();
    inta = 1'b1;
    tick();
    inta = 1'b0;
  endtask

  task automatic init(input logic [7:0] icw4);
    wr(1'b0, 8'h13);
    wr(1'b1, 8'h40);
    wr(1'b1, icw4);
    wr(1'b1, 8'h00);
  endtask

  initial begin
    reset = 1'b1; wr_en = 0; wr_a0 = 0; wr_data = 0;
    rd_en = 0; rd_a0 = 0; inta = 0; irq_req = 0;
    tick(); tick();
    chk("rst_imr", imr, 8'hFF);
    chk("rst_isr", isr, 8'h00);
    chk("rst_int", {7'd0, int_out}, 8'h00);
    chk("rst_vv", {7'd0, vector_valid}, 8'h00);
    reset = 1'b0;

    init(8'h01);
    chk("ocw1_imr", imr, 8'h00);

    irq_req = 8'h24;
    tick(); tick();
    chk("int_on", {7'd0, int_out}, 8'h01);
    ack();
    chk("ack1_isr", isr, 8'h04);
    chk("ack1_clr", clear_req, 8'h04);
    chk("wait2_int", {7'd0, int_out}, 8'h00);
    irq_req = 8'h20;
    ack();
    chk("vec42", vector_out, 8'h42);
    chk("vv_on", {7'd0, vector_valid}, 8'h01);
    tick();
    chk("vv_off", {7'd0, vector_valid}, 8'h00);
    chk("nest_ir5", {7'd0, int_out}, 8'h00);
    wr(1'b0, 8'h20);
    chk("ns_eoi", isr, 8'h00);
    tick();
    chk("ir5_int", {7'd0, int_out}, 8'h01);
    irq_req = 8'h00;

    init(8'h03);
    wr(1'b0, 8'h80);
    irq_req = 8'h08;
    tick();
    ack();
    chk("aeoi_isr1", isr, 8'h08);
    irq_req = 8'h00;
    ack();
    chk("vec43", vector_out, 8'h43);
    chk("aeoi_clr", isr, 8'h00);
    irq_req = 8'h11;
    tick(); tick();
    ack();
    chk("rot_clr", clear_req, 8'h10);
    irq_req = 8'h01;
    ack();
    chk("vec44", vector_out, 8'h44);
    irq_req = 8'h00;

    init(8'h01);
    irq_req = 8'h04;
    tick();
    ack();
    irq_req = 8'h00;
    ack();
    chk("isr04", isr, 8'h04);
    irq_req = 8'h40;
    tick(); tick();
    chk("nest_blk", {7'd0, int_out}, 8'h00);
    wr(1'b0, 8'hC5);
    tick(); tick();
    chk("setprio", {7'd0, int_out}, 8'h01);
    irq_req = 8'h00;
    wr(1'b0, 8'h62);
    chk("sp_eoi", isr, 8'h00);

    ack();
    chk("spur_clr", clear_req, 8'h00);
    ack();
    chk("vec47", vector_out, 8'h47);
    chk("spur_isr", isr, 8'h00);

    irq_req = 8'h02;
    wr(1'b0, 8'h0C);
    rd(1'b0);
    chk("poll_rd", rd_data, 8'h81);
    chk("poll_isr", isr, 8'h02);
    chk("poll_clr", clear_req, 8'h02);
    irq_req = 8'h00;

    wr(1'b0, 8'h0B);
    rd(1'b0);
    chk("rd_isr", rd_data, 8'h02);
    wr(1'b1, 8'hF0);
    rd(1'b1);
    chk("rd_imr", rd_data, 8'hF0);
    wr(1'b0, 8'h0A);
    irq_req = 8'h05;
    rd(1'b0);
    chk("rd_irr", rd_data, 8'h05);
    irq_req = 8'h00;

    ack();
    wr(1'b0, 8'h13);
    chk("icw1_imr", imr, 8'hFF);
    chk("icw1_isr", isr, 8'h00);
    wr(1'b1, 8'h40);
    wr(1'b1, 8'h01);
    ack();
    chk("abort_vv", {7'd0, vector_valid}, 8'h00);
    ack();
    chk("abort_vv2", {7'd0, vector_valid}, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
